fifo2_sram: RTL and testbench

FIFO2_SRAM -- requirements
Module: fifo2_sram

---
 rtl/fifo2_pkg.sv | 22 ++
 rtl/fifo2_bank.sv | 27 ++
 rtl/fifo2_sram.sv | 148 ++++++++++++++
 tb/tb_fifo2_sram.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo2_pkg.sv
// Shared constants, read-mode encoding and bank-geometry helper for the
// banked-SRAM synchronous FIFO.
package fifo2_pkg;

  localparam int DEF_DSIZE     = 8;
  localparam int DEF_ASIZE     = 10;
  localparam int DEF_NBANK     = 8;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_MARGIN = 4;
  localparam int DEF_FWFT      = 0;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } rd_mode_e;

  // Number of pointer MSBs used as bank index; a single bank needs none.
  function automatic int bank_bits(input int nbank);
    return (nbank <= 1) ? 0 : $clog2(nbank);
  endfunction

endpackage

// File: rtl/fifo2_bank.sv
// One SRAM bank: single write port, single synchronous read port, active-low
// chip selects. Contents and read register are intentionally not reset.
module fifo2_bank
  import fifo2_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             wcs_n,
  input  logic [AW-1:0]    waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rcs_n,
  input  logic [AW-1:0]    raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**AW];

  // The read register only moves on a selected read, so it holds its word
  // between reads and the top can use it directly as the output stage.
  always_ff @(posedge clk) begin
    if (!wcs_n) mem[waddr] <= wdata;
    if (!rcs_n) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo2_sram.sv
// Synchronous FIFO over NBANK synchronous-read SRAM banks, with standard or
// first-word-fall-through read timing and sticky overflow/underflow flags.
module fifo2_sram
  import fifo2_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int NBANK     = DEF_NBANK,
  parameter int AF_MARGIN = DEF_AF_MARGIN,
  parameter int AE_MARGIN = DEF_AE_MARGIN,
  parameter int FWFT      = DEF_FWFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata_in,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam rd_mode_e       MODE    = (FWFT != 0) ? fifo2_pkg::FWFT : fifo2_pkg::STD;
  localparam int             BB      = bank_bits(NBANK);
  localparam int             BW      = (BB == 0) ? 1 : BB;
  localparam int             AW      = ASIZE - BB;
  localparam int             CW      = ASIZE + 1;
  localparam logic [ASIZE:0] DEPTH_C = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_TH   = DEPTH_C - CW'(AF_MARGIN);
  localparam logic [ASIZE:0] AE_TH   = CW'(AE_MARGIN);

  logic [ASIZE-1:0] wptr, rptr;
  logic             ovf_q, unf_q;
  logic             ov_q;       // FWFT head word valid in the bank read register
  logic             rd_seen_q;  // STD: at least one word has been read since reset
  logic [BW-1:0]    wbank, rbank, rbank_q;
  logic [AW-1:0]    waddr, raddr;
  logic             wr_acc, rd_acc, fetch;
  logic [ASIZE:0]   mem_cnt;
  logic [NBANK-1:0] wcs_n, rcs_n;
  logic [DSIZE-1:0] bank_q [NBANK];
  logic             out_valid;

  // Status flags are decoded from registered count/ov_q only.
  assign wfull         = (count == DEPTH_C);
  assign rempty        = (MODE == fifo2_pkg::FWFT) ? ~ov_q : (count == '0);
  assign walmost_full  = (count >= AF_TH);
  assign ralmost_empty = (count <= AE_TH);
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

  assign wr_acc  = winc & ~wfull & ~flush;
  assign rd_acc  = rinc & ~rempty & ~flush;
  assign mem_cnt = count - CW'(ov_q);

  // FWFT refills the head register whenever it is empty or being popped and
  // words remain in SRAM; STD simply reads on each accepted pop.
  assign fetch = (MODE == fifo2_pkg::FWFT)
               ? ((mem_cnt != '0) & (~ov_q | rd_acc) & ~flush)
               : rd_acc;

  generate
    if (BB == 0) begin : g_one_bank
      assign wbank = '0;
      assign rbank = '0;
    end else begin : g_multi_bank
      assign wbank = wptr[ASIZE-1 -: BW];
      assign rbank = rptr[ASIZE-1 -: BW];
    end
  endgenerate

  assign waddr = wptr[AW-1:0];
  assign raddr = rptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ov_q      <= 1'b0;
      rd_seen_q <= 1'b0;
      rbank_q   <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ASIZE'(1);
      if (fetch) begin
        rptr      <= rptr + ASIZE'(1);
        rbank_q   <= rbank;
        rd_seen_q <= 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (winc && wfull)  ovf_q <= 1'b1;
      if (rinc && rempty) unf_q <= 1'b1;
      if (MODE == fifo2_pkg::FWFT) begin
        if (fetch)       ov_q <= 1'b1;
        else if (rd_acc) ov_q <= 1'b0;
      end
    end
  end

  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      assign wcs_n[b] = ~(wr_acc && (wbank == BW'(b)));
      assign rcs_n[b] = ~(fetch && (rbank == BW'(b)));

      fifo2_bank #(
        .DSIZE (DSIZE),
        .AW    (AW)
      ) u_bank (
        .clk   (clk),
        .wcs_n (wcs_n[b]),
        .waddr (waddr),
        .wdata (wdata_in),
        .rcs_n (rcs_n[b]),
        .raddr (raddr),
        .rdata (bank_q[b])
      );
    end
  endgenerate

  // Bank mux uses the index captured with the read, so rptr may already
  // point into a different bank without disturbing rdata.
  assign out_valid = (MODE == fifo2_pkg::FWFT) ? ov_q : rd_seen_q;
  assign rdata     = out_valid ? bank_q[rbank_q] : '0;

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
  a_one_wbank:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~wcs_n));
  a_one_rbank:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~rcs_n));

endmodule

// File: tb/tb_fifo2_sram.sv
// Bench for fifo2_sram: randomized and directed traffic on a standard-read
// instance against a queue model, plus directed checks on an FWFT instance.
module tb_fifo2_sram;

  localparam int DSIZE = 8;
  localparam int ASIZE = 10;
  localparam int DEPTH = 1 << ASIZE;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // standard-read instance
  logic [DSIZE-1:0] wdata = '0;
  logic             winc = 1'b0, rinc = 1'b0, flush = 1'b0;
  logic [DSIZE-1:0] rdata;
  logic             wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [ASIZE:0]   count;

  // FWFT instance
  logic [DSIZE-1:0] wdata_f = '0;
  logic             winc_f = 1'b0, rinc_f = 1'b0, flush_f = 1'b0;
  logic [DSIZE-1:0] rdata_f;
  logic             wfull_f, rempty_f, walmost_full_f, ralmost_empty_f, overflow_f, underflow_f;
  logic [ASIZE:0]   count_f;

  fifo2_sram #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NBANK(8), .AF_MARGIN(4), .AE_MARGIN(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wdata_in(wdata), .winc(winc), .rinc(rinc), .flush(flush),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo2_sram #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NBANK(8), .AF_MARGIN(4), .AE_MARGIN(4), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .wdata_in(wdata_f), .winc(winc_f), .rinc(rinc_f), .flush(flush_f),
    .rdata(rdata_f), .wfull(wfull_f), .rempty(rempty_f), .walmost_full(walmost_full_f),
    .ralmost_empty(ralmost_empty_f), .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  // scoreboard / reference model state
  int               errors = 0;
  int               checks = 0;
  logic [DSIZE-1:0] model_q[$];
  logic [DSIZE-1:0] exp_q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  bit               rd_pend = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One standard-instance cycle: drive at negedge and advance the model to
  // the state the FIFO should hold after the following posedge.
  task automatic std_cycle(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit f);
    int sz;
    @(negedge clk);
    winc = w; wdata = d; rinc = r; flush = f;
    sz = model_q.size();
    rd_pend = 1'b0;
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_unf = 1'b1;
      if (r && sz > 0) begin
        exp_q.push_back(model_q.pop_front());
        rd_pend = 1'b1;
      end
      if (w && sz < DEPTH) model_q.push_back(d);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rempty"}, longint'(rempty), 1);
    chk({tag, "_wfull"}, longint'(wfull), 0);
    chk({tag, "_count"}, longint'(count), 0);
    chk({tag, "_walmost_full"}, longint'(walmost_full), 0);
    chk({tag, "_ralmost_empty"}, longint'(ralmost_empty), 1);
    chk({tag, "_overflow"}, longint'(overflow), 0);
    chk({tag, "_underflow"}, longint'(underflow), 0);
    chk({tag, "_rdata"}, longint'(rdata), 0);
    chk({tag, "_f_rempty"}, longint'(rempty_f), 1);
    chk({tag, "_f_count"}, longint'(count_f), 0);
    chk({tag, "_f_rdata"}, longint'(rdata_f), 0);
    chk({tag, "_f_wfull"}, longint'(wfull_f), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    winc = 1'b0; rinc = 1'b0; flush = 1'b0;
    winc_f = 1'b0; rinc_f = 1'b0; flush_f = 1'b0;
    rd_pend = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_reset_values(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: pops the expected word when a read was issued and compares all
  // standard-instance status against the model every cycle
  always @(posedge clk) begin : monitor
    bit fire;
    int sz;
    fire = rd_pend;
    #2;
    if (fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_rdata at %0t: got %0h, expected none queued", $time, rdata);
      end else begin
        chk("std_rdata", longint'(rdata), longint'(exp_q.pop_front()));
      end
    end
    sz = model_q.size();
    chk("std_count", longint'(count), longint'(sz));
    chk("std_wfull", longint'(wfull), longint'(sz == DEPTH));
    chk("std_rempty", longint'(rempty), longint'(sz == 0));
    chk("std_walmost_full", longint'(walmost_full), longint'(sz >= DEPTH - 4));
    chk("std_ralmost_empty", longint'(ralmost_empty), longint'(sz <= 4));
    chk("std_overflow", longint'(overflow), longint'(m_ovf));
    chk("std_underflow", longint'(underflow), longint'(m_unf));
  end

  initial begin
    logic [DSIZE-1:0] fq[$];
    int wp, rp;

    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fill to full, then one dropped write
    for (int i = 0; i < DEPTH; i++) std_cycle(1'b1, DSIZE'(i), 1'b0, 1'b0);
    std_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b0);

    // drain in order, then one read past empty
    for (int i = 0; i < DEPTH; i++) std_cycle(1'b0, '0, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b0);

    // simultaneous write and read at full, then drain
    std_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) std_cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    std_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) std_cycle(1'b0, '0, 1'b1, 1'b0);

    // write at empty with concurrent read, then flush at 600 with traffic
    std_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) std_cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    std_cycle(1'b0, '0, 1'b1, 1'b0);
    std_cycle(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    std_cycle(1'b1, DSIZE'($urandom), 1'b1, 1'b1);
    std_cycle(1'b0, '0, 1'b0, 1'b0);

    // randomized phases biased toward filling and draining
    for (int p = 0; p < 4; p++) begin
      wp = (p % 2 == 0) ? 90 : 15;
      rp = (p % 2 == 0) ? 15 : 90;
      for (int i = 0; i < 800; i++)
        std_cycle($urandom_range(0, 99) < wp, DSIZE'($urandom),
                  $urandom_range(0, 99) < rp, $urandom_range(0, 499) == 0);
    end
    std_cycle(1'b0, '0, 1'b0, 1'b1);

    // reset in the middle of a burst at count 300, then a short refill
    while (model_q.size() < 300)
      std_cycle($urandom_range(0, 3) != 0, DSIZE'($urandom), $urandom_range(0, 3) == 0, 1'b0);
    do_reset("midrst");
    std_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    std_cycle(1'b1, 8'h22, 1'b0, 1'b0);
    std_cycle(1'b1, 8'h33, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b1, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b0);
    std_cycle(1'b0, '0, 1'b0, 1'b0);

    // FWFT: single word latency and pop
    @(negedge clk);
    winc_f = 1'b1; wdata_f = 8'hA5;
    @(negedge clk);
    winc_f = 1'b0;
    chk("fwft_rempty_n1", longint'(rempty_f), 1);
    @(negedge clk);
    chk("fwft_rempty_n2", longint'(rempty_f), 0);
    chk("fwft_rdata_n2", longint'(rdata_f), 8'hA5);
    chk("fwft_count_n2", longint'(count_f), 1);
    rinc_f = 1'b1;
    @(negedge clk);
    chk("fwft_rempty_pop", longint'(rempty_f), 1);
    chk("fwft_count_pop", longint'(count_f), 0);
    @(negedge clk);
    rinc_f = 1'b0;
    chk("fwft_underflow", longint'(underflow_f), 1);

    // FWFT: back-to-back pops without bubbles
    for (int k = 0; k < 6; k++) fq.push_back(DSIZE'($urandom));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      winc_f = 1'b1; wdata_f = fq[k];
    end
    @(negedge clk);
    winc_f = 1'b0;
    repeat (2) @(negedge clk);
    chk("fwft_count_burst", longint'(count_f), 6);
    for (int k = 0; k < 6; k++) begin
      chk("fwft_stream_rempty", longint'(rempty_f), 0);
      chk("fwft_stream_rdata", longint'(rdata_f), longint'(fq[k]));
      chk("fwft_stream_count", longint'(count_f), longint'(6 - k));
      rinc_f = 1'b1;
      @(negedge clk);
    end
    rinc_f = 1'b0;
    chk("fwft_rempty_drained", longint'(rempty_f), 1);
    chk("fwft_count_drained", longint'(count_f), 0);

    // FWFT: flush with a held head word clears everything
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      winc_f = 1'b1; wdata_f = DSIZE'($urandom);
    end
    @(negedge clk);
    winc_f = 1'b0;
    repeat (2) @(negedge clk);
    chk("fwft_pre_flush_rempty", longint'(rempty_f), 0);
    flush_f = 1'b1; winc_f = 1'b1; rinc_f = 1'b1;
    @(negedge clk);
    flush_f = 1'b0; winc_f = 1'b0; rinc_f = 1'b0;
    chk("fwft_flush_rempty", longint'(rempty_f), 1);
    chk("fwft_flush_count", longint'(count_f), 0);
    chk("fwft_flush_underflow", longint'(underflow_f), 0);
    chk("fwft_flush_overflow", longint'(overflow_f), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
